bus_write_checker: RTL and testbench

//  Parametrised self-checking monitor on the cpu6502 bus. It replaces per-cycle ad-hoc asserts in CPU tests.
//  It holds a table of DEPTH expected write transactions (addr, data, mask, cycle, strict).
//  It tracks a cycle counter and compares each sampled bus write, in order, against the next expected entry.
//  It reports done, pass, error count and first-failure location.

---
 rtl/bus_write_checker_if.sv | 14 +
 rtl/bus_write_checker.sv | 171 +++++++++++++++++
 tb/tb_bus_write_checker.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_write_checker_if.sv
// bus_write_checker_if: cpu6502 bus sample group (strobe, address, write data, direction).
// The CPU/bench side uses the master modport; the checker uses the slave modport.
interface bus_write_checker_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              bus_valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] odata;
  logic              rw;

  modport master (output bus_valid, addr, odata, rw);
  modport slave  (input  bus_valid, addr, odata, rw);
endinterface

// File: rtl/bus_write_checker.sv
// bus_write_checker: in-order checker of CPU bus writes against a table of
// expected transactions. Optional macro CHECKER_TIMEOUT_EN ends a run at
// cycle MAX_CYCLES, charging every unchecked entry as an error.
module bus_write_checker #(
  parameter int              ADDR_W     = 16,
  parameter int              DATA_W     = 8,
  parameter int              DEPTH      = 8,
  parameter int              CNT_W      = 16,
  parameter logic [CNT_W-1:0] MAX_CYCLES = 16'h0400,
  localparam int             IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int             CW         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [CNT_W-1:0]  cfg_cycle,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic              cfg_strict,
  input  logic              arm,
  input  logic [CW-1:0]     arm_count,
  bus_write_checker_if.slave bus,
  output logic [CNT_W-1:0]  cycle,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [IW-1:0]     err_idx,
  output logic [CNT_W-1:0]  err_cycle,
  output logic              timeout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state;

  logic [ADDR_W-1:0] t_addr   [DEPTH];
  logic [DATA_W-1:0] t_data   [DEPTH];
  logic [DATA_W-1:0] t_mask   [DEPTH];
  logic [CNT_W-1:0]  t_cycle  [DEPTH];
  logic              t_strict [DEPTH];

  logic [CW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] arm_len;
  logic [IW-1:0] pidx;

  logic sample, hit, late, consume, fail, last;
  logic [7:0] err_inc;

  assign pidx    = ptr[IW-1:0];
  assign arm_len = (arm_count > CW'(DEPTH)) ? CW'(DEPTH) : arm_count;

  // Evaluate the current bus sample and the pending entry against each other.
  always_comb begin
    sample  = bus.bus_valid && !bus.rw;
    hit     = (bus.addr == t_addr[pidx])
           && ((bus.odata & t_mask[pidx]) == (t_data[pidx] & t_mask[pidx]))
           && (!t_strict[pidx] || (cycle == t_cycle[pidx]));
    late    = t_strict[pidx] && (cycle > t_cycle[pidx]);
    consume = sample || late;
    fail    = sample ? !hit : late;
    last    = (ptr + CW'(1)) == cnt;
    err_inc = (err_count == '1) ? err_count : err_count + 8'd1;
  end

`ifdef CHECKER_TIMEOUT_EN
  logic        tmo_hit;
  logic [31:0] tmo_sum;
  logic [7:0]  tmo_err;
  assign tmo_hit = (cycle == MAX_CYCLES);
  assign tmo_sum = 32'(err_count) + 32'(cnt - ptr);
  assign tmo_err = (tmo_sum > 32'd255) ? 8'hff : tmo_sum[7:0];
`else
  logic       tmo_hit;
  logic [7:0] tmo_err;
  assign tmo_hit = 1'b0;
  assign tmo_err = '0;
`endif

  // Expectation table: writable only while no run is in progress; an
  // arm in the same cycle takes priority and drops the write.
  always_ff @(posedge clk) begin
    if (cfg_we && !arm && (state != S_RUN) && (int'(cfg_idx) < DEPTH)) begin
      t_addr[cfg_idx]   <= cfg_addr;
      t_data[cfg_idx]   <= cfg_data;
      t_mask[cfg_idx]   <= cfg_mask;
      t_cycle[cfg_idx]  <= cfg_cycle;
      t_strict[cfg_idx] <= cfg_strict;
    end
  end

  // Run control FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      cycle     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      err_idx   <= '0;
      err_cycle <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            cycle     <= '0;
            ptr       <= '0;
            cnt       <= arm_len;
            err_count <= '0;
            err_idx   <= '0;
            err_cycle <= '0;
            timeout   <= 1'b0;
            if (arm_len == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (cycle != '1) cycle <= cycle + CNT_W'(1);
          if (tmo_hit) begin
            // Timeout charges all remaining entries; the first of them is
            // reported as the failure point if nothing failed earlier.
            err_count <= tmo_err;
            if (err_count == '0) begin
              err_idx   <= pidx;
              err_cycle <= cycle;
            end
            timeout <= 1'b1;
            ptr     <= cnt;
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else if (consume) begin
            ptr <= ptr + CW'(1);
            if (fail) begin
              err_count <= err_inc;
              if (err_count == '0) begin
                err_idx   <= pidx;
                err_cycle <= cycle;
              end
            end
            if (last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !fail;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_write_checker.sv
// tb_bus_write_checker: table vectors, directed multi-cycle sequences and
// randomized runs checked against a cycle-by-cycle model of the checking rules.
`timescale 1ns/1ps
module tb_bus_write_checker;
  localparam int          DEPTH    = 8;
  localparam logic [15:0] MAX_MAIN = 16'h0400;
  localparam logic [15:0] MAX_TMO  = 16'h0020;
  localparam int          TR       = 256;
`ifdef CHECKER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [15:0] cfg_cycle, cfg_addr;
  logic [7:0]  cfg_data, cfg_mask;
  logic        cfg_strict;
  logic        arm;
  logic [3:0]  arm_count;

  logic [15:0] cycle, err_cycle, t_cycle, t_err_cycle;
  logic        busy, done, pass, timeout, t_busy, t_done, t_pass, t_timeout;
  logic [7:0]  err_count, t_err_count;
  logic [2:0]  err_idx, t_err_idx;

  bus_write_checker_if #(.ADDR_W(16), .DATA_W(8)) bif ();

  bus_write_checker #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .CNT_W(16), .MAX_CYCLES(MAX_MAIN)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_cycle(cfg_cycle),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_mask(cfg_mask), .cfg_strict(cfg_strict),
    .arm(arm), .arm_count(arm_count), .bus(bif),
    .cycle(cycle), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .err_idx(err_idx), .err_cycle(err_cycle), .timeout(timeout));

  bus_write_checker #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .CNT_W(16), .MAX_CYCLES(MAX_TMO)) u_tmo (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_cycle(cfg_cycle),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_mask(cfg_mask), .cfg_strict(cfg_strict),
    .arm(arm), .arm_count(arm_count), .bus(bif),
    .cycle(t_cycle), .busy(t_busy), .done(t_done), .pass(t_pass), .err_count(t_err_count),
    .err_idx(t_err_idx), .err_cycle(t_err_cycle), .timeout(t_timeout));

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference copy of the expectation table and the per-cycle bus trace.
  logic [15:0] m_addr [DEPTH];
  logic [7:0]  m_data [DEPTH];
  logic [7:0]  m_mask [DEPTH];
  logic        m_strict [DEPTH];
  logic [15:0] m_cyc [DEPTH];
  logic        tr_v [TR];
  logic        tr_rw [TR];
  logic [15:0] tr_a [TR];
  logic [7:0]  tr_d [TR];

  typedef struct {
    logic [15:0] ea; logic [7:0] ed; logic [7:0] em; logic es; logic [15:0] ec;
    logic [15:0] wa; logic [7:0] wd; int wc;
    logic xpass; logic [7:0] xerr; logic [15:0] xcyc;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cfg_we = 1'b0; cfg_idx = '0; cfg_cycle = '0; cfg_addr = '0; cfg_data = '0;
    cfg_mask = '0; cfg_strict = 1'b0; arm = 1'b0; arm_count = '0;
    bif.bus_valid = 1'b0; bif.rw = 1'b1; bif.addr = '0; bif.odata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input int i, input logic [15:0] a, input logic [7:0] d,
                           input logic [7:0] m, input logic s, input logic [15:0] c);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'(i); cfg_addr = a; cfg_data = d; cfg_mask = m;
    cfg_strict = s; cfg_cycle = c;
    @(negedge clk);
    cfg_we = 1'b0;
    m_addr[i] = a; m_data[i] = d; m_mask[i] = m; m_strict[i] = s; m_cyc[i] = c;
  endtask

  task automatic clear_trace();
    for (int k = 0; k < TR; k++) begin
      tr_v[k] = 1'b0; tr_rw[k] = 1'b1; tr_a[k] = '0; tr_d[k] = '0;
    end
  endtask

  task automatic put_wr(input int k, input logic [15:0] a, input logic [7:0] d);
    tr_v[k] = 1'b1; tr_rw[k] = 1'b0; tr_a[k] = a; tr_d[k] = d;
  endtask

  task automatic put_rd(input int k, input logic [15:0] a, input logic [7:0] d);
    tr_v[k] = 1'b1; tr_rw[k] = 1'b1; tr_a[k] = a; tr_d[k] = d;
  endtask

  // Arm, then play the trace one entry per clock (entry k is seen at run cycle k).
  // dk = negedge index at which done was first seen, -1 if not within budget.
  task automatic run_trace(input int n, input int budget, input bit cfg_with_arm,
                           input int poke_k, output int dk);
    @(negedge clk);
    arm = 1'b1; arm_count = 4'(n);
    if (cfg_with_arm) begin
      cfg_we = 1'b1; cfg_idx = '0; cfg_addr = 16'hdead; cfg_data = 8'h00;
      cfg_mask = 8'hff; cfg_strict = 1'b1; cfg_cycle = '0;
    end
    @(negedge clk);
    arm = 1'b0; cfg_we = 1'b0;
    dk = -1;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        dk = k;
        break;
      end
      bif.bus_valid = (k < TR) ? tr_v[k] : 1'b0;
      bif.rw        = (k < TR) ? tr_rw[k] : 1'b1;
      bif.addr      = (k < TR) ? tr_a[k] : '0;
      bif.odata     = (k < TR) ? tr_d[k] : '0;
      if (k == poke_k) begin
        cfg_we = 1'b1; cfg_idx = '0; cfg_addr = 16'hbeef; cfg_data = 8'h77;
        cfg_mask = 8'hff; cfg_strict = 1'b1; cfg_cycle = 16'h0001;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
    bif.bus_valid = 1'b0; bif.rw = 1'b1;
  endtask

  // Reference: walk the cycles, consuming table entries in order by the checking rules.
  task automatic model(input int n, input int budget, input int maxc, input bit tmo_en,
                       output int dk, output int ec, output int eidx, output int ecyc, output bit to);
    int p;
    p = 0; ec = 0; eidx = 0; ecyc = 0; to = 1'b0; dk = -1;
    if (n == 0) begin
      dk = 0;
      return;
    end
    for (int c = 0; c < budget; c++) begin
      bit err;
      bit s;
      err = 1'b0;
      if (tmo_en && c == maxc) begin
        if (ec == 0) begin eidx = p; ecyc = c; end
        ec = ec + (n - p);
        if (ec > 255) ec = 255;
        to = 1'b1;
        p = n;
      end else begin
        s = (c < TR) && tr_v[c] && !tr_rw[c];
        if (s) begin
          err = (tr_a[c] != m_addr[p]) || (((tr_d[c] ^ m_data[p]) & m_mask[p]) != 8'h00)
             || (m_strict[p] && c != int'(m_cyc[p]));
          p++;
        end else if (m_strict[p] && c > int'(m_cyc[p])) begin
          err = 1'b1;
          p++;
        end
        if (err) begin
          if (ec == 0) begin eidx = p - 1; ecyc = c; end
          if (ec < 255) ec++;
        end
      end
      if (p == n) begin
        if (c + 1 < budget) dk = c + 1;
        return;
      end
    end
  endtask

  task automatic run_cmp(input string nm, input int n, input int budget,
                         input bit cfg_with_arm, input int poke_k);
    int dk, edk, eec, eidx, ecyc;
    bit eto;
    model(n, budget, int'(MAX_MAIN), TMO_EN, edk, eec, eidx, ecyc, eto);
    run_trace(n, budget, cfg_with_arm, poke_k, dk);
    check({nm, ".done_at"}, dk, edk);
    check({nm, ".err_count"}, err_count, eec);
    check({nm, ".pass"}, pass, (edk >= 0 && eec == 0));
    check({nm, ".timeout"}, timeout, eto);
    if (eec > 0) begin
      check({nm, ".err_idx"}, err_idx, eidx);
      check({nm, ".err_cycle"}, err_cycle, ecyc);
    end
    if (edk < 0) do_reset();
  endtask

  logic [15:0] pool [4];
  int dk;

  initial begin
    // Single-entry vectors: {entry, write (cycle -1 = none), expected pass/err/err_cycle}.
    vecs[0] = '{16'h0099, 8'hff, 8'hff, 1'b0, 16'h0000, 16'h0099, 8'hff, 3,    1'b1, 8'd0, 16'h0000};
    vecs[1] = '{16'h0099, 8'hff, 8'hff, 1'b0, 16'h0000, 16'h0099, 8'hfe, 3,    1'b0, 8'd1, 16'h0003};
    vecs[2] = '{16'h0099, 8'hff, 8'hfe, 1'b0, 16'h0000, 16'h0099, 8'hfe, 3,    1'b1, 8'd0, 16'h0000};
    vecs[3] = '{16'h0099, 8'h5a, 8'h0f, 1'b0, 16'h0000, 16'h0099, 8'hfa, 5,    1'b1, 8'd0, 16'h0000};
    vecs[4] = '{16'h0099, 8'hff, 8'hff, 1'b0, 16'h0000, 16'h0098, 8'hff, 2,    1'b0, 8'd1, 16'h0002};
    vecs[5] = '{16'h0120, 8'h33, 8'hff, 1'b1, 16'h0010, 16'h0120, 8'h33, 16,   1'b1, 8'd0, 16'h0000};
    vecs[6] = '{16'h0120, 8'h33, 8'hff, 1'b1, 16'h0010, 16'h0120, 8'h33, 15,   1'b0, 8'd1, 16'h000f};
    vecs[7] = '{16'h0120, 8'h33, 8'hff, 1'b1, 16'h0010, 16'h0120, 8'h33, 18,   1'b0, 8'd1, 16'h0011};
    vecs[8] = '{16'h0120, 8'h33, 8'hff, 1'b1, 16'h0005, 16'h0000, 8'h00, -1,   1'b0, 8'd1, 16'h0006};
    vecs[9] = '{16'h0077, 8'h12, 8'h00, 1'b0, 16'h0000, 16'h0077, 8'hed, 1,    1'b1, 8'd0, 16'h0000};
    pool[0] = 16'h0099; pool[1] = 16'h0200; pool[2] = 16'h0300; pool[3] = 16'h0400;

    idle_inputs();
    reset = 1'b1;
    clear_trace();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.pass", pass, 0);
    check("reset.err_count", err_count, 0);
    check("reset.cycle", cycle, 0);
    check("reset.timeout", timeout, 0);

    for (int i = 0; i < 10; i++) begin
      cfg_write(0, vecs[i].ea, vecs[i].ed, vecs[i].em, vecs[i].es, vecs[i].ec);
      clear_trace();
      if (vecs[i].wc >= 0) put_wr(vecs[i].wc, vecs[i].wa, vecs[i].wd);
      run_trace(1, 64, 1'b0, -1, dk);
      check($sformatf("vec%0d.done", i), (dk >= 0), 1);
      check($sformatf("vec%0d.pass", i), pass, vecs[i].xpass);
      check($sformatf("vec%0d.err_count", i), err_count, vecs[i].xerr);
      if (vecs[i].xerr != 0) begin
        check($sformatf("vec%0d.err_cycle", i), err_cycle, vecs[i].xcyc);
        check($sformatf("vec%0d.err_idx", i), err_idx, 0);
      end
    end

    // Two strict entries hit exactly on their cycles.
    cfg_write(0, 16'h0099, 8'hff, 8'hff, 1'b1, 16'h0031);
    cfg_write(1, 16'h0200, 8'h55, 8'hff, 1'b1, 16'h0040);
    clear_trace();
    put_wr(16'h31, 16'h0099, 8'hff);
    put_wr(16'h40, 16'h0200, 8'h55);
    run_trace(2, 128, 1'b0, -1, dk);
    check("strict2.done_at", dk, 32'h41);
    check("strict2.pass", pass, 1);
    check("strict2.err_count", err_count, 0);

    // Late strict write: error reported at the late cycle, then entry 1 checked.
    cfg_write(1, 16'h0200, 8'h55, 8'hff, 1'b0, 16'h0000);
    clear_trace();
    put_wr(16'h32, 16'h0099, 8'hff);
    put_wr(16'h35, 16'h0200, 8'h55);
    run_trace(2, 128, 1'b0, -1, dk);
    check("late.done_at", dk, 32'h36);
    check("late.err_cycle", err_cycle, 16'h0032);
    check("late.err_idx", err_idx, 0);
    check("late.err_count", err_count, 1);
    check("late.pass", pass, 0);

    // Non-strict entries with reads and unstrobed writes interleaved.
    cfg_write(0, 16'h0300, 8'h12, 8'hff, 1'b0, 16'h0000);
    cfg_write(1, 16'h0301, 8'h34, 8'hff, 1'b0, 16'h0000);
    cfg_write(2, 16'h0302, 8'h56, 8'h0f, 1'b0, 16'h0000);
    clear_trace();
    put_rd(1, 16'h0300, 8'h00);
    put_wr(3, 16'h0300, 8'h12);
    put_rd(4, 16'h0301, 8'hee);
    tr_rw[5] = 1'b0; tr_a[5] = 16'h0abc; tr_d[5] = 8'h99;
    put_wr(7, 16'h0301, 8'h34);
    put_rd(9, 16'h0302, 8'h00);
    put_wr(12, 16'h0302, 8'ha6);
    run_trace(3, 64, 1'b0, -1, dk);
    check("mixed.done_at", dk, 13);
    check("mixed.pass", pass, 1);
    check("mixed.err_count", err_count, 0);

    // Writes after DONE are not checked.
    bif.bus_valid = 1'b1; bif.rw = 1'b0; bif.addr = 16'hffff; bif.odata = 8'h00;
    repeat (3) @(negedge clk);
    bif.bus_valid = 1'b0; bif.rw = 1'b1;
    check("afterdone.err_count", err_count, 0);
    check("afterdone.done", done, 1);
    check("afterdone.pass", pass, 1);

    // Zero-length run completes one cycle after arm.
    run_trace(0, 8, 1'b0, -1, dk);
    check("empty.done_at", dk, 0);
    check("empty.pass", pass, 1);

    // Reset mid-run: abort to IDLE immediately.
    clear_trace();
    put_wr(1, 16'h1234, 8'h00);
    run_trace(3, 4, 1'b0, -1, dk);
    check("midrun.busy", busy, 1);
    check("midrun.err_count", err_count, 1);
    reset = 1'b1;
    #1;
    check("midreset.busy", busy, 0);
    check("midreset.err_count", err_count, 0);
    check("midreset.done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    // Table survives reset, a cfg write during RUN, and a cfg write alongside arm.
    clear_trace();
    put_wr(3, 16'h0300, 8'h12);
    put_wr(7, 16'h0301, 8'h34);
    put_wr(12, 16'h0302, 8'ha6);
    run_cmp("rerun", 3, 64, 1'b0, 0);
    run_cmp("runpoke", 3, 64, 1'b0, 2);
    run_cmp("armcfg", 3, 64, 1'b1, -1);

    // Timeout instance: three non-strict entries, no writes.
    do_reset();
    clear_trace();
    run_trace(3, 32, 1'b0, -1, dk);
    check("tmo.pre_done", t_done, 0);
    check("tmo.pre_busy", t_busy, 1);
    @(negedge clk);
    if (TMO_EN) begin
      check("tmo.done", t_done, 1);
      check("tmo.timeout", t_timeout, 1);
      check("tmo.err_count", t_err_count, 3);
      check("tmo.err_idx", t_err_idx, 0);
      check("tmo.err_cycle", t_err_cycle, 16'h0020);
      check("tmo.pass", t_pass, 0);
    end else begin
      check("notmo.busy", t_busy, 1);
      check("notmo.done", t_done, 0);
      check("notmo.timeout", t_timeout, 0);
    end
    do_reset();

    // Randomized runs against the reference model.
    for (int it = 0; it < 30; it++) begin
      int n;
      int w;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++)
        cfg_write(i, pool[$urandom_range(0, 3)], 8'($urandom),
                  ($urandom_range(0, 1) != 0) ? 8'hff : 8'($urandom),
                  ($urandom_range(0, 3) == 0), 16'(i * 6 + $urandom_range(2, 4)));
      clear_trace();
      w = 0;
      for (int k = 0; k < 60; k++) begin
        if (w < n && m_strict[w] && k == int'(m_cyc[w]) && $urandom_range(0, 3) != 0) begin
          put_wr(k, m_addr[w], m_data[w]);
          w++;
        end else begin
          case ($urandom_range(0, 5))
            0, 1: ;
            2: put_rd(k, 16'($urandom), 8'($urandom));
            default: if (w < n) begin
              put_wr(k, m_addr[w], m_data[w] ^ (($urandom_range(0, 5) == 0) ? 8'h01 : 8'h00));
              w++;
            end
          endcase
        end
      end
      run_cmp($sformatf("rnd%0d", it), n, 120, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
